// File: rtl/dff_cond_pkg.sv
// Shared types and defaults for the input-conditioning stages that feed the
// team's D flip-flop.
package dff_cond_pkg;

   typedef enum logic [1:0] {
      IDLE_LOW   = 2'b00,
      CHECK_HIGH = 2'b01,
      IDLE_HIGH  = 2'b11,
      CHECK_LOW  = 2'b10
   } db_state_e;

   localparam int SYNC_STAGES_DEF = 2;
   localparam int DB_CYCLES_DEF   = 4;

endpackage

// File: rtl/sync_chain.sv
// Plain 1-bit flop chain for bringing an asynchronous level into clk.
// Asynchronous active-low reset clears every stage.
module sync_chain #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain_q;
   logic [STAGES-1:0] chain_d;

   // No logic between stages: each flop only re-samples its predecessor.
   always_comb begin
      chain_d = {chain_q[STAGES-2:0], d};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         chain_q <= '0;
      end else begin
         chain_q <= chain_d;
      end
   end

   assign q = chain_q[STAGES-1];

endmodule

// File: rtl/dff_input_debounce.sv
// Synchronise and debounce a raw level, producing a clean dout plus
// single-cycle rise/fall strobes for the downstream flop.
module dff_input_debounce
   import dff_cond_pkg::*;
#(
   parameter int SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int DB_CYCLES   = DB_CYCLES_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic dout,
   output logic rise,
   output logic fall,
   output logic stable
);

   localparam int CNT_W = $clog2(DB_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic s;

   db_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             dout_q, dout_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;
   logic             stable_q, stable_d;

   sync_chain #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (din),
      .q     (s)
   );

   // cnt holds how many consecutive samples of the candidate level have been
   // seen; the accept transition clears it, so it never passes CNT_LAST.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dout_d  = dout_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      case (state_q)
         IDLE_LOW: begin
            if (s) begin
               state_d = CHECK_HIGH;
               cnt_d   = CNT_ONE;
            end
         end
         CHECK_HIGH: begin
            if (!s) begin
               state_d = IDLE_LOW;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE_HIGH;
               dout_d  = 1'b1;
               rise_d  = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         IDLE_HIGH: begin
            if (!s) begin
               state_d = CHECK_LOW;
               cnt_d   = CNT_ONE;
            end
         end
         CHECK_LOW: begin
            if (s) begin
               state_d = IDLE_HIGH;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE_LOW;
               dout_d  = 1'b0;
               fall_d  = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = IDLE_LOW;
            cnt_d   = '0;
         end
      endcase
      stable_d = (state_d == IDLE_LOW) || (state_d == IDLE_HIGH);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE_LOW;
         cnt_q    <= '0;
         dout_q   <= 1'b0;
         rise_q   <= 1'b0;
         fall_q   <= 1'b0;
         stable_q <= 1'b1;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         dout_q   <= dout_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
         stable_q <= stable_d;
      end
   end

   assign dout   = dout_q;
   assign rise   = rise_q;
   assign fall   = fall_q;
   assign stable = stable_q;

endmodule

// File: doc/dff_input_debounce.md
Name: dff_input_debounce

Overview:
- Conditioning stage directly upstream of the team's synchronous-reset D flip-flop.
- Takes a raw asynchronous level (switch, pin, or another clock domain) and synchronises it into clk.
- Debounces it over a programmable number of cycles and drives a clean level onto the flop's d input.
- Also emits single-cycle rise/fall strobes so downstream logic can act on debounced edges without extra edge detectors.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops (legal range 2..4).
- DB_CYCLES, 4, consecutive synchronised samples required to accept a new level (legal range 2..65535).
- CNT_W, $clog2(DB_CYCLES+1), counter width (derived; not overridden).

Ports:
- clk  input  1  system clock, all state on posedge.
- reset  input  1  asynchronous, active-low reset.
- din  input  1  raw asynchronous input level.
- dout  output  1  debounced level (feeds downstream d).
- rise  output  1  one-cycle pulse when dout goes 0->1.
- fall  output  1  one-cycle pulse when dout goes 1->0.
- stable  output  1  high while no candidate transition is being qualified.

Behaviour:
- Reset:
  - reset low immediately, without waiting for clk: sync chain all 0, state IDLE_LOW, cnt=0, dout=0, rise=0, fall=0, stable=1.
  - Release takes effect on the first posedge with reset high.
- Synchroniser:
  - SYNC_STAGES-deep flop chain on din; last stage = s.
  - No logic between stages.
  - The FSM uses only s.
- FSM states: IDLE_LOW, CHECK_HIGH, IDLE_HIGH, CHECK_LOW.
- IDLE_LOW:
  - s=1 -> CHECK_HIGH, cnt<=1.
  - else stay.
- CHECK_HIGH:
  - s=0 -> IDLE_LOW, cnt<=0 (glitch rejected, no pulse).
  - s=1 and cnt==DB_CYCLES-1 -> IDLE_HIGH, dout<=1, rise<=1, cnt<=0.
  - otherwise cnt<=cnt+1.
- IDLE_HIGH / CHECK_LOW: mirror of the above with s inverted; the accept transition sets dout<=0, fall<=1.
- Outputs:
  - rise/fall are registered, high for exactly one cycle, and never both high in the same cycle.
  - stable = 1 in IDLE_LOW/IDLE_HIGH, 0 in CHECK states (registered with state).
  - dout changes only on accept transitions.
- Latency:
  - din held at a new level for the whole window -> dout updates on posedge number SYNC_STAGES+DB_CYCLES after the first edge that samples the new level.
  - rise/fall assert on that same edge.
- Glitch rule: any run of s shorter than DB_CYCLES consecutive samples never changes dout.
- Counter: saturates logically at DB_CYCLES-1; it never wraps, because the accept transition clears it.
- Toggle during check: an opposite sample in a CHECK state returns to the originating IDLE state in one cycle. A new check can start on the next differing sample; there is no dead time.
- Reset mid-check: abandons the check. dout returns to 0 even if it was 1, and no pulse is generated on release.
- din constant after reset release: if din=1 at release, dout rises after SYNC_STAGES+DB_CYCLES cycles with a rise pulse. This is intended power-up behaviour.

Decomposition:
- Shared package dff_cond_pkg:
  - FSM state typedef (2-bit encoding IDLE_LOW=00, CHECK_HIGH=01, IDLE_HIGH=11, CHECK_LOW=10).
  - Default constants for SYNC_STAGES and DB_CYCLES.
- One sub-module: sync_chain
  - Parameterised depth, 1-bit, same async active-low reset.
  - Reusable by other input stages.
- FSM, counter and pulse generation live in the top module.

Test Plan (SYNC_STAGES=2, DB_CYCLES=4, clk period 20):
- Clean rise: reset low 2 cycles, release; din=1 from cycle 3 and held -> dout=1 and rise=1 exactly at posedge 3+6; rise=0 the next cycle; stable=0 during cycles 3+3..3+5.
- Glitch reject: from dout=0, din=1 for 3 cycles then 0 -> dout stays 0, rise never asserts, state returns to IDLE_LOW, stable returns to 1.
- Clean fall: from dout=1, din=0 held -> dout=0 and fall=1 six posedges after the first sampled 0; fall width exactly one cycle.
- Chatter: din toggles every cycle for 20 cycles, then holds 1 -> no pulses during chatter; a single rise 6 posedges after the final toggle; dout then stays 1.
- Reset mid-operation: dout=1 and CHECK_LOW in progress (cnt=2); assert reset between clock edges -> dout, rise, fall go 0 before the next posedge; after release with din=0, no fall pulse and dout stays 0.
- Back-to-back: din high 6 cycles then low 6 cycles, repeated twice -> alternating rise/fall pulses (4 total), each exactly one cycle; rise and fall never coincide.
